pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage core. It detects load-use hazards and EXE-stage taken branches, and sequences multi-cycle data-memory accesses through a req/ready handshake. It drives stall and flush controls for the PC, IF/ID, ID/EXE and EXE/MEM pipeline registers, and a bubble control for MEM/WB. It also keeps saturating stall and flush event counters for debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipe_hazard_ctrl.sv | 130 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

    localparam int REG_ADDR_W_DEF = 5;

    localparam logic CTRL_ENABLE  = 1'b1;
    localparam logic CTRL_DISABLE = 1'b0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - saturating event counter
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use/branch hazard and data-memory wait controller
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] exe_wr_addr,
    input  logic                  exe_wr_en,
    input  logic                  exe_DM_read,
    input  logic                  exe_branch_taken,
    input  logic                  mem_DM_read,
    input  logic                  mem_DM_write,
    input  logic                  dm_ready,
    output logic                  dm_req,
    output logic                  pc_stall,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_exe_stall,
    output logic                  id_exe_flush,
    output logic                  exe_mem_stall,
    output logic                  mem_wb_bubble,
    output logic                  pc_sel_branch,
    output logic                  mem_err,
    output logic                  halted,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    hz_state_e         state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic              mem_err_nxt;

    logic mem_acc, in_err, mem_freeze, hold;
    logic rs1_hit, rs2_hit, load_use, take_branch, lu_stall;

    always_comb begin
        mem_acc     = mem_DM_read | mem_DM_write;
        in_err      = (state == ST_ERR);
        mem_freeze  = mem_acc & ~dm_ready & ~in_err;
        hold        = in_err | mem_freeze;
        // r0 is a writable GPR on this core, so it takes part in the match
        rs1_hit     = id_rs1_used & (id_rs1_addr == exe_wr_addr);
        rs2_hit     = id_rs2_used & (id_rs2_addr == exe_wr_addr);
        load_use    = exe_DM_read & exe_wr_en & (rs1_hit | rs2_hit);
        take_branch = exe_branch_taken & ~hold;
        // a taken branch flushes the dependent instruction, so no stall is needed
        lu_stall    = load_use & ~hold & ~exe_branch_taken;
    end

    assign dm_req        = mem_acc & ~in_err;
    assign pc_stall      = hold | lu_stall;
    assign if_id_stall   = hold | lu_stall;
    assign id_exe_stall  = hold;
    assign exe_mem_stall = hold;
    assign mem_wb_bubble = hold;
    assign if_id_flush   = take_branch;
    assign id_exe_flush  = take_branch | lu_stall;
    assign pc_sel_branch = take_branch;
    assign halted        = in_err;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err;
        case (state)
            ST_RUN: begin
                if (mem_freeze) begin
                    state_nxt    = ST_MEM_WAIT;
                    wait_cnt_nxt = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // leaving on a dropped request too keeps a withdrawn access from wedging the core
                if (!mem_freeze) begin
                    state_nxt    = ST_RUN;
                    wait_cnt_nxt = '0;
                end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                    state_nxt   = ST_ERR;
                    mem_err_nxt = CTRL_ENABLE;
                end else begin
                    wait_cnt_nxt = wait_cnt + 1'b1;
                end
            end
            ST_ERR: begin
                state_nxt = ST_ERR;
            end
            default: begin
                state_nxt    = ST_RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= CTRL_DISABLE;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            mem_err  <= mem_err_nxt;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_stall),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_sel_branch),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed vector bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

    localparam int AW = 5;
    localparam int CW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] id_rs1_addr = '0, id_rs2_addr = '0, exe_wr_addr = '0;
    logic          id_rs1_used = 0, id_rs2_used = 0, exe_wr_en = 0, exe_DM_read = 0;
    logic          exe_branch_taken = 0, mem_DM_read = 0, mem_DM_write = 0, dm_ready = 0;
    logic          dm_req, pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush;
    logic          exe_mem_stall, mem_wb_bubble, pc_sel_branch, mem_err, halted;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .exe_wr_addr(exe_wr_addr), .exe_wr_en(exe_wr_en), .exe_DM_read(exe_DM_read),
        .exe_branch_taken(exe_branch_taken),
        .mem_DM_read(mem_DM_read), .mem_DM_write(mem_DM_write), .dm_ready(dm_ready),
        .dm_req(dm_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_exe_stall(id_exe_stall), .id_exe_flush(id_exe_flush),
        .exe_mem_stall(exe_mem_stall), .mem_wb_bubble(mem_wb_bubble),
        .pc_sel_branch(pc_sel_branch), .mem_err(mem_err), .halted(halted),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // {dm_req, pc_stall, if_id_stall, if_id_flush, id_exe_stall, id_exe_flush, exe_mem_stall, mem_wb_bubble, pc_sel_branch}
    logic [8:0] outs;
    assign outs = {dm_req, pc_stall, if_id_stall, if_id_flush, id_exe_stall,
                   id_exe_flush, exe_mem_stall, mem_wb_bubble, pc_sel_branch};

    localparam logic [8:0] O_NONE   = 9'b0_0000_0000;
    localparam logic [8:0] O_LU     = 9'b0_1100_1000;
    localparam logic [8:0] O_BR     = 9'b0_0010_1001;
    localparam logic [8:0] O_REQ    = 9'b1_0000_0000;
    localparam logic [8:0] O_FREEZE = 9'b1_1101_0110;
    localparam logic [8:0] O_ERR    = 9'b0_1101_0110;

    typedef struct {
        string      name;
        logic [4:0] rs1, rs2, wr;
        logic       rs1_u, rs2_u, wr_en, ld, br, mrd, mwr, rdy;
        logic [8:0] exp;
    } vec_t;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        id_rs1_addr = '0; id_rs2_addr = '0; exe_wr_addr = '0;
        id_rs1_used = 0; id_rs2_used = 0; exe_wr_en = 0; exe_DM_read = 0;
        exe_branch_taken = 0; mem_DM_read = 0; mem_DM_write = 0; dm_ready = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; exe_wr_addr = v.wr;
        id_rs1_used = v.rs1_u; id_rs2_used = v.rs2_u; exe_wr_en = v.wr_en;
        exe_DM_read = v.ld; exe_branch_taken = v.br;
        mem_DM_read = v.mrd; mem_DM_write = v.mwr; dm_ready = v.rdy;
    endtask

    vec_t vecs[$];
    int   exp_stall;
    int   edges;

    initial begin
        //           name          rs1 rs2 wr  r1u r2u wen ld br mrd mwr rdy exp
        vecs.push_back('{"idle",        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_NONE});
        vecs.push_back('{"lu_rs2",      1, 3, 3, 0, 1, 1, 1, 0, 0, 0, 0, O_LU});
        vecs.push_back('{"lu_rs1_r0",   0, 7, 0, 1, 0, 1, 1, 0, 0, 0, 0, O_LU});
        vecs.push_back('{"rs1_unused",  3, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, O_NONE});
        vecs.push_back('{"no_wr_en",    3, 3, 3, 1, 1, 0, 1, 0, 0, 0, 0, O_NONE});
        vecs.push_back('{"not_load",    3, 3, 3, 1, 1, 1, 0, 0, 0, 0, 0, O_NONE});
        vecs.push_back('{"addr_diff",   2, 4, 3, 1, 1, 1, 1, 0, 0, 0, 0, O_NONE});
        vecs.push_back('{"branch",      0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR});
        vecs.push_back('{"branch_lu",   1, 3, 3, 0, 1, 1, 1, 1, 0, 0, 0, O_BR});
        vecs.push_back('{"zero_wait",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, O_REQ});
        vecs.push_back('{"store_wait",  0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, O_FREEZE});
        vecs.push_back('{"frz_br_lu",   1, 3, 3, 0, 1, 1, 1, 1, 1, 0, 0, O_FREEZE});

        // reset state, with the clock running
        #2;
        chk("reset_outs", {23'd0, outs}, {23'd0, O_NONE});
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_mem_err", {31'd0, mem_err}, 32'd0);
        chk("reset_cnts", {stall_cnt, flush_cnt}, 32'd0);
        #10 rst = 1'b1;

        // combinational vectors: inputs are withdrawn before each clock edge
        foreach (vecs[i]) begin
            next_cycle();
            apply(vecs[i]);
            #3;
            chk($sformatf("vec_%s", vecs[i].name), {23'd0, outs}, {23'd0, vecs[i].exp});
            #2;
            clear_inputs();
        end
        chk("vec_cnts_untouched", {stall_cnt, flush_cnt}, 32'd0);

        // load-use across an edge: one stall cycle, then the load leaves EXE
        next_cycle();
        exe_DM_read = 1; exe_wr_en = 1; exe_wr_addr = 3; id_rs2_addr = 3; id_rs2_used = 1;
        #3 chk("lu_seq_c0", {23'd0, outs}, {23'd0, O_LU});
        next_cycle();
        clear_inputs();
        #1 chk("lu_seq_c1", {23'd0, outs}, {23'd0, O_NONE});
        chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);
        exp_stall = 1;

        // branch coincident with load-use
        next_cycle();
        exe_DM_read = 1; exe_wr_en = 1; exe_wr_addr = 3; id_rs2_addr = 3; id_rs2_used = 1;
        exe_branch_taken = 1;
        #3 chk("brlu_seq", {23'd0, outs}, {23'd0, O_BR});
        next_cycle();
        clear_inputs();
        #1 chk("brlu_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("brlu_stall_cnt", {16'd0, stall_cnt}, exp_stall);

        // four-cycle memory wait; a branch in EXE is held off until the access completes
        next_cycle();
        mem_DM_read = 1;
        for (int c = 0; c < 4; c++) begin
            exe_branch_taken = (c >= 2);
            #3 chk($sformatf("memwait_c%0d", c), {23'd0, outs}, {23'd0, O_FREEZE});
            next_cycle();
        end
        exp_stall += 4;
        dm_ready = 1;
        #3 chk("memwait_ready", {23'd0, outs}, {23'd0, O_REQ | O_BR});
        next_cycle();
        clear_inputs();
        #1 chk("memwait_stall_cnt", {16'd0, stall_cnt}, exp_stall);
        chk("memwait_flush_cnt", {16'd0, flush_cnt}, 32'd2);
        chk("memwait_halted", {31'd0, halted}, 32'd0);

        // asynchronous reset in the middle of a wait
        next_cycle();
        mem_DM_read = 1;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b0;
        clear_inputs();
        #1;
        chk("arst_outs", {23'd0, outs}, {23'd0, O_NONE});
        chk("arst_cnts", {stall_cnt, flush_cnt}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        #2 rst = 1'b1;

        // timeout: ERR follows the RUN freeze cycle plus TO wait cycles
        next_cycle();
        mem_DM_read = 1;
        edges = 0;
        while (!halted && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("timeout_edges", edges, TO + 1);
        exe_branch_taken = 1;
        #2;
        chk("err_outs", {23'd0, outs}, {23'd0, O_ERR});
        chk("err_flags", {30'd0, mem_err, halted}, 32'd3);
        clear_inputs();
        dm_ready = 1;
        repeat (3) next_cycle();
        chk("err_sticky_outs", {23'd0, outs}, {23'd0, O_ERR});
        chk("err_sticky_flags", {30'd0, mem_err, halted}, 32'd3);
        rst = 1'b0;
        #1;
        chk("err_reset_flags", {30'd0, mem_err, halted}, 32'd0);
        chk("err_reset_outs", {23'd0, outs}, {23'd0, O_REQ & 9'd0});
        #3 rst = 1'b1;
        clear_inputs();
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
